// File: rtl/dque_issue_scheduler.sv
// Decode-queue consumer: pulls 2-wide bundles by request/ack, holds one, dual-issues or splits on RAW.
// Latency: bundle visible on o_issue the cycle after the acked request (1 cycle).
// Backpressure: i_ex_ready=0 freezes buffer/state/o_issue and suppresses the pop request.
//
// Ports: i_clk/i_rstn (async active-low), decode-queue handshake (i_dque_sch_ready,
// i_dque_sch_ack, i_decode, o_sch_dque_request), execute lanes (i_ex_ready, o_issue,
// o_issue_valid), i_flush (sync), o_split_cnt (saturating hazard-split count).

package dque_pkg;
    typedef struct packed {
        logic        valid;
        logic        rd_wren;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] instr;
    } decode_t;
endpackage

module dque_issue_scheduler
    import dque_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_dque_sch_ready,
    input  logic                i_dque_sch_ack,
    input  decode_t [1:0]       i_decode,
    output logic                o_sch_dque_request,
    input  logic                i_ex_ready,
    input  logic                i_flush,
    output decode_t [1:0]       o_issue,
    output logic [1:0]          o_issue_valid,
    output logic [CNT_W-1:0]    o_split_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_HEAD  = 2'd2,
        S_TAIL  = 2'd3
    } state_t;

    state_t             state;
    decode_t            buf0;
    decode_t            buf1;
    logic [CNT_W-1:0]   split_cnt;
    logic               haz;
    logic               will_empty;
    logic               load;

    // Younger slot reads the older slot's destination; x0 writes never create a dependency.
    assign haz = buf1.valid & buf0.valid & buf0.rd_wren & (buf0.rd_addr != 5'd0)
               & ((buf0.rd_addr == buf1.rs1_addr) | (buf0.rd_addr == buf1.rs2_addr));

    // Request in the cycle the buffer drains so a new bundle lands with no bubble.
    assign will_empty = (state == S_EMPTY)
                      | (i_ex_ready & (((state == S_FULL) & ~haz)
                                       | (state == S_HEAD)
                                       | (state == S_TAIL)));

    assign o_sch_dque_request = i_rstn & ~i_flush & i_dque_sch_ready & will_empty;
    assign load               = i_dque_sch_ack & o_sch_dque_request;
    assign o_split_cnt        = split_cnt;

    // Lane drive depends only on registered state/buffer, so outputs are glitch-free of inputs.
    always_comb begin
        o_issue       = '0;
        o_issue_valid = 2'b00;
        case (state)
            S_FULL: begin
                o_issue[0] = buf0;
                if (haz) begin
                    o_issue_valid = 2'b01;
                end else begin
                    o_issue[1]    = buf1;
                    o_issue_valid = 2'b11;
                end
            end
            S_HEAD: begin
                o_issue[0]    = buf0;
                o_issue_valid = 2'b01;
            end
            S_TAIL: begin
                // Younger instruction moves to lane0 so lane1 is never valid alone.
                o_issue[0]    = buf1;
                o_issue_valid = 2'b01;
            end
            default: begin
                o_issue       = '0;
                o_issue_valid = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_EMPTY;
            buf0      <= '0;
            buf1      <= '0;
            split_cnt <= '0;
        end else if (i_flush) begin
            state      <= S_EMPTY;
            buf0.valid <= 1'b0;
            buf1.valid <= 1'b0;
        end else if (load) begin
            // Captured slot valids pick the next state, overriding the drain transition.
            buf0 <= i_decode[0];
            buf1 <= i_decode[1];
            case ({i_decode[1].valid, i_decode[0].valid})
                2'b11:   state <= S_FULL;
                2'b01:   state <= S_HEAD;
                2'b10:   state <= S_TAIL;
                default: state <= S_EMPTY;
            endcase
        end else if (i_ex_ready) begin
            case (state)
                S_FULL: begin
                    if (haz) begin
                        state <= S_TAIL;
                        if (~&split_cnt) begin
                            split_cnt <= split_cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= S_EMPTY;
                    end
                end
                S_HEAD:  state <= S_EMPTY;
                S_TAIL:  state <= S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_dque_issue_scheduler.sv
// Directed bench for dque_issue_scheduler: reset, streaming, RAW split, saturation,
// backpressure, partial bundles, flush, asynchronous reset mid-bundle.
// Inputs change #1 after posedge; outputs are sampled on negedge.

module tb_dque_issue_scheduler;
    import dque_pkg::*;

    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               dq_ready;
    logic               dq_ack;
    logic               ack_auto;
    logic               ack_man;
    decode_t [1:0]      dec;
    logic               req;
    logic               ex_ready;
    logic               flush;
    decode_t [1:0]      issue;
    logic [1:0]         ivld;
    logic [CNT_W-1:0]   cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decode_t sa[4];
    decode_t sb[4];
    decode_t h0, h1, z0, z1, p0, p1, pinv;

    always #5 clk = ~clk;

    // Queue model: acks combinationally in the request cycle unless a stray ack is being injected.
    assign dq_ack = ack_auto ? (dq_ready & req) : ack_man;

    dque_issue_scheduler #(.CNT_W(CNT_W)) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_dque_sch_ready   (dq_ready),
        .i_dque_sch_ack     (dq_ack),
        .i_decode           (dec),
        .o_sch_dque_request (req),
        .i_ex_ready         (ex_ready),
        .i_flush            (flush),
        .o_issue            (issue),
        .o_issue_valid      (ivld),
        .o_split_cnt        (cnt)
    );

    function automatic decode_t mk(input logic v, input logic w, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] ins);
        decode_t d;
        d.valid    = v;
        d.rd_wren  = w;
        d.rd_addr  = rd;
        d.rs1_addr = rs1;
        d.rs2_addr = rs2;
        d.instr    = ins;
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; dq_ready = 1'b1; ack_auto = 1'b1; ack_man = 1'b0;
        ex_ready = 1'b1; flush = 1'b0; dec = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", ivld); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_checks++; if (issue !== '0) begin n_fail++; $display("FAIL reset_issue: got %h want 0", issue); end
        rstn = 1'b1;
        #1;
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b want 1", req); end
        tick();
        dq_ready = 1'b0;
    endtask

    task automatic test_stream;
        logic exp_req;
        for (int i = 0; i < 5; i++) begin
            dq_ready = (i < 4);
            ex_ready = 1'b1;
            if (i < 4) begin
                dec[0] = sa[i];
                dec[1] = sb[i];
            end
            @(negedge clk);
            exp_req = (i < 4);
            n_checks++; if (req !== exp_req) begin n_fail++; $display("FAIL stream_req[%0d]: got %b want %b", i, req, exp_req); end
            if (i == 0) begin
                n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 00", i, ivld); end
            end else begin
                n_checks++; if (ivld !== 2'b11) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 11", i, ivld); end
                n_checks++; if (issue[0] !== sa[i-1]) begin n_fail++; $display("FAIL stream_lane0[%0d]: got %h want %h", i, issue[0], sa[i-1]); end
                n_checks++; if (issue[1] !== sb[i-1]) begin n_fail++; $display("FAIL stream_lane1[%0d]: got %h want %h", i, issue[1], sb[i-1]); end
            end
            tick();
        end
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL stream_drained: got %b want 00", ivld); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL stream_cnt: got %0d want 0", cnt); end
        tick();
    endtask

    task automatic test_raw_split;
        dq_ready = 1'b1; ex_ready = 1'b1;
        dec[0] = h0; dec[1] = h1;
        @(negedge clk);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL raw_req0: got %b want 1", req); end
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL raw_valid1: got %b want 01", ivld); end
        n_checks++; if (issue[0] !== h0) begin n_fail++; $display("FAIL raw_lane0_c1: got %h want %h", issue[0], h0); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL raw_req1: got %b want 0", req); end
        tick();
        dec[0] = z0; dec[1] = z1;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL raw_valid2: got %b want 01", ivld); end
        n_checks++; if (issue[0] !== h1) begin n_fail++; $display("FAIL raw_lane0_c2: got %h want %h", issue[0], h1); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL raw_req2: got %b want 1", req); end
        n_checks++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL raw_cnt: got %0d want 1", cnt); end
        tick();
        dq_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b11) begin n_fail++; $display("FAIL x0_valid: got %b want 11", ivld); end
        n_checks++; if (issue[0] !== z0) begin n_fail++; $display("FAIL x0_lane0: got %h want %h", issue[0], z0); end
        n_checks++; if (issue[1] !== z1) begin n_fail++; $display("FAIL x0_lane1: got %h want %h", issue[1], z1); end
        n_checks++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL x0_cnt: got %0d want 1", cnt); end
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL x0_drained: got %b want 00", ivld); end
        tick();
    endtask

    task automatic test_saturation;
        // Starting from cnt=1 in S_EMPTY, a continuous hazard stream splits every other cycle:
        // 28 edges give 14 splits (cnt=15), two more edges add one split that must saturate.
        dq_ready = 1'b1; ex_ready = 1'b1;
        dec[0] = h0; dec[1] = h1;
        repeat (28) tick();
        @(negedge clk);
        n_checks++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", cnt); end
        repeat (2) tick();
        dq_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", cnt); end
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL sat_tail_valid: got %b want 01", ivld); end
        n_checks++; if (issue[0] !== h1) begin n_fail++; $display("FAIL sat_tail_lane0: got %h want %h", issue[0], h1); end
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL sat_drained: got %b want 00", ivld); end
        tick();
    endtask

    task automatic test_backpressure;
        dq_ready = 1'b1; ex_ready = 1'b0;
        dec[0] = sa[0]; dec[1] = sb[0];
        @(negedge clk);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL bp_req0: got %b want 1", req); end
        tick();
        // Stray acks with a different bundle must not disturb the held one.
        ack_auto = 1'b0; ack_man = 1'b1;
        dec[0] = sa[1]; dec[1] = sb[1];
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks++; if (ivld !== 2'b11) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 11", c, ivld); end
            n_checks++; if (issue[0] !== sa[0]) begin n_fail++; $display("FAIL bp_lane0[%0d]: got %h want %h", c, issue[0], sa[0]); end
            n_checks++; if (issue[1] !== sb[0]) begin n_fail++; $display("FAIL bp_lane1[%0d]: got %h want %h", c, issue[1], sb[0]); end
            n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req[%0d]: got %b want 0", c, req); end
            tick();
        end
        ack_auto = 1'b1; ack_man = 1'b0; ex_ready = 1'b1;
        dec = '0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b11) begin n_fail++; $display("FAIL bp_release_valid: got %b want 11", ivld); end
        n_checks++; if (issue[0] !== sa[0]) begin n_fail++; $display("FAIL bp_release_lane0: got %h want %h", issue[0], sa[0]); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL bp_release_req: got %b want 1", req); end
        tick();
        dq_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL bp_drained: got %b want 00", ivld); end
        tick();
    endtask

    task automatic test_partial;
        dq_ready = 1'b1; ex_ready = 1'b1;
        dec[0] = p0; dec[1] = pinv;
        @(negedge clk);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL part_req0: got %b want 1", req); end
        tick();
        dec[0] = pinv; dec[1] = p1;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL part_head_valid: got %b want 01", ivld); end
        n_checks++; if (issue[0] !== p0) begin n_fail++; $display("FAIL part_head_lane0: got %h want %h", issue[0], p0); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL part_head_req: got %b want 1", req); end
        tick();
        dec = '0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL part_tail_valid: got %b want 01", ivld); end
        n_checks++; if (issue[0] !== p1) begin n_fail++; $display("FAIL part_tail_lane0: got %h want %h", issue[0], p1); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL part_tail_req: got %b want 1", req); end
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL part_empty_valid: got %b want 00", ivld); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL part_empty_req: got %b want 1", req); end
        tick();
        dq_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL part_idle_valid: got %b want 00", ivld); end
        tick();
    endtask

    task automatic test_flush;
        dq_ready = 1'b1; ex_ready = 1'b1;
        dec[0] = h0; dec[1] = h1;
        @(negedge clk);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL flush_req0: got %b want 1", req); end
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b01) begin n_fail++; $display("FAIL flush_split_valid: got %b want 01", ivld); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (issue[0] !== h1) begin n_fail++; $display("FAIL flush_tail_lane0: got %h want %h", issue[0], h1); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b want 0", req); end
        tick();
        flush = 1'b0; ex_ready = 1'b0;
        dec = '0;
        @(negedge clk);
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL flush_empty_valid: got %b want 00", ivld); end
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL flush_empty_req: got %b want 1", req); end
        n_checks++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL flush_cnt_kept: got %0d want 15", cnt); end
        tick();
        dq_ready = 1'b0; ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset;
        dq_ready = 1'b1; ex_ready = 1'b0;
        dec[0] = sa[2]; dec[1] = sb[2];
        tick();
        @(negedge clk);
        n_checks++; if (ivld !== 2'b11) begin n_fail++; $display("FAIL areset_loaded: got %b want 11", ivld); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (ivld !== 2'b00) begin n_fail++; $display("FAIL areset_valid: got %b want 00", ivld); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %b want 0", req); end
        n_checks++; if (issue !== '0) begin n_fail++; $display("FAIL areset_issue: got %h want 0", issue); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d want 0", cnt); end
        dq_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sa[i] = mk(1'b1, 1'b1, 5'(i + 1),  5'd10, 5'd11, 32'h0000_1000 + 32'(i));
            sb[i] = mk(1'b1, 1'b1, 5'(i + 20), 5'd12, 5'd13, 32'h0000_2000 + 32'(i));
        end
        h0   = mk(1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h0050_8293);  // addi x5, x1, 5
        h1   = mk(1'b1, 1'b1, 5'd6, 5'd5, 5'd1, 32'h0012_8333);  // add  x6, x5, x1
        z0   = mk(1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h0050_8013);  // addi x0, x1, 5
        z1   = mk(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 32'h0000_03b3);  // add  x7, x0, x0
        p0   = mk(1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0000_3000);
        p1   = mk(1'b1, 1'b1, 5'd9, 5'd8, 5'd8, 32'h0000_3001);
        pinv = mk(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 32'h0000_DEAD);

        test_reset();
        test_stream();
        test_raw_split();
        test_saturation();
        test_backpressure();
        test_partial();
        test_flush();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
